// File: rtl/edge_pkg.sv
// Shared definitions for the edge pulse bank: edge-select encodings,
// parameter defaults and the per-channel edge gating helper.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int WIDTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_DEF    = 4;

  // Select which registered edge(s) of a channel reach its Pulse output.
  function automatic logic edge_select(input mode_e mode, input logic rise, input logic fall);
    logic take_rise;
    logic take_fall;
    take_rise = (mode == MODE_RISE) || (mode == MODE_BOTH);
    take_fall = (mode == MODE_FALL) || (mode == MODE_BOTH);
    return (rise && take_rise) || (fall && take_fall);
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchroniser chain, debounce counter, filtered level
// and registered one-cycle rise/fall pulses.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE    = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W   = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_in;

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Shift the raw input one stage deeper into the synchroniser each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  // Debounce: count consecutive mismatching cycles, flip the level when the
  // count reaches DEBOUNCE and flag the direction of that flip for one cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned; otherwise synthesis infers a latch.
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_in == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = ~level_q;
      rise_d  = ~level_q;
      fall_d  = level_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state register; reset leaves the level low with no pending edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking ones would collapse the synchroniser chain.
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/edge_pulse_bank.sv
// Bank of independent debounced edge detectors with a global edge select.
// All state lives in the channels; this level only gates Pulse and Any.
module edge_pulse_bank
  import edge_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE    = DEBOUNCE_DEF
) (
  input  logic             sysclk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Input,
  input  logic [1:0]       Mode,
  output logic [WIDTH-1:0] Level,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall,
  output logic [WIDTH-1:0] Pulse,
  output logic             Any
);

  mode_e mode;
  assign mode = mode_e'(Mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_chan (
      .clk   (sysclk),
      .rst_n (Reset),
      .raw_in(Input[i]),
      .level (Level[i]),
      .rise  (Rise[i]),
      .fall  (Fall[i])
    );
  end

  // Mode gating is purely combinational so a Mode change acts immediately.
  always_comb begin
    Pulse = '0;
    for (int i = 0; i < WIDTH; i++) begin
      Pulse[i] = edge_select(mode, Rise[i], Fall[i]);
    end
  end

  assign Any = |Pulse;

endmodule

// File: doc/edge_pulse_bank.md
EDGE_PULSE_BANK -- requirements
Module: edge_pulse_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent input channels, 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flip-flops per channel, 2..4.
REQ-003 SHALL have parameter DEBOUNCE, default 4: consecutive stable cycles required before the filtered level changes, 1..255.
REQ-004 SHALL have port `sysclk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port `Reset`, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port `Input`, input, WIDTH bits: asynchronous raw signals (buttons, coin sensors).
REQ-007 SHALL have port `Mode`, input, 2 bits: global edge select; 00 none, 01 rise, 10 fall, 11 both.
REQ-008 SHALL have port `Level`, output, WIDTH bits: synchronised, debounced level per channel.
REQ-009 SHALL have port `Rise`, output, WIDTH bits: one-cycle pulse per channel on a 0->1 transition of `Level`.
REQ-010 SHALL have port `Fall`, output, WIDTH bits: one-cycle pulse per channel on a 1->0 transition of `Level`.
REQ-011 SHALL have port `Pulse`, output, WIDTH bits: mode-selected edge pulse per channel.
REQ-012 SHALL have port `Any`, output, 1 bit: OR-reduction of `Pulse`.

Function
REQ-013 Each channel SHALL pass `Input[i]` through a SYNC_STAGES-deep flip-flop chain; `sync[i]` denotes the last stage output.
REQ-014 Each channel SHALL hold a counter of width clog2(DEBOUNCE+1) and a registered `Level[i]`.
REQ-015 On each edge where `sync[i]` == `Level[i]`, the counter SHALL clear to 0.
REQ-016 On each edge where `sync[i]` != `Level[i]` and the counter < DEBOUNCE-1, the counter SHALL increment by 1.
REQ-017 On each edge where `sync[i]` != `Level[i]` and the counter == DEBOUNCE-1, `Level[i]` SHALL toggle and the counter SHALL clear.
REQ-018 The counter SHALL never exceed DEBOUNCE-1 and SHALL never wrap.
REQ-019 `Rise[i]`/`Fall[i]` SHALL be registered and high for exactly the one cycle following the edge on which `Level[i]` toggled (first cycle of the new level).
REQ-020 Latency: `Input` stable from before edge 1 SHALL produce the `Level` change and `Rise`/`Fall` after edge SYNC_STAGES+DEBOUNCE (6 with defaults).
REQ-021 A mismatch lasting fewer than DEBOUNCE consecutive synchronised cycles SHALL produce no `Level` change and no pulse.
REQ-022 `Rise[i]` and `Fall[i]` SHALL never be high in the same cycle.
REQ-023 A channel SHALL NOT pulse again until DEBOUNCE further cycles have elapsed.
REQ-024 `Pulse[i]` SHALL equal (`Rise[i]` & `Mode[0]`) | (`Fall[i]` & `Mode[1]`), combinationally from registers and `Mode`.
REQ-025 A `Mode` change SHALL take effect in the same cycle and SHALL NOT alter `Rise`, `Fall` or `Level`.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL each pulse, and `Any` SHALL be high once for that cycle.

Reset
REQ-027 While `Reset` = 0, all sync flip-flops, counters, `Level`, `Rise` and `Fall` SHALL be 0 immediately, independent of `sysclk`.
REQ-028 `Pulse` and `Any` SHALL be 0 while `Reset` = 0.
REQ-029 Reset asserted mid-debounce or mid-pulse SHALL abort the pending change with no pulse emitted.
REQ-030 After `Reset` deasserts with `Input[i]` held high, channel i SHALL emit one `Rise` SYNC_STAGES+DEBOUNCE cycles later, because reset level is 0.

Structure
REQ-031 Shared package edge_pkg SHALL hold the Mode encodings (MODE_NONE, MODE_RISE, MODE_FALL, MODE_BOTH) and the parameter defaults.
REQ-032 Sub-module edge_channel SHALL implement one channel (sync chain, debounce counter, `Level`, `Rise`, `Fall`), instantiated WIDTH times by a generate loop.
REQ-033 Top-level logic SHALL be limited to the `Pulse`/`Any` gating.
REQ-034 The design SHALL contain no latches and no derived clocks.

Verification
REQ-035 Defaults, Mode=01: `Input[0]` 0->1 held -> `Level[0]` = 1 and `Rise[0]` = 1 for one cycle after edge 6; `Pulse[0]` = `Any` = 1 in the same cycle.
REQ-036 3-cycle high glitch on `Input[1]` -> `Level[1]`, `Rise[1]`, `Fall[1]` and `Any` stay 0 throughout.
REQ-037 Mode=10: `Input[2]` 1->0 after stable high -> `Fall[2]` = `Pulse[2]` = 1 for one cycle; on the preceding rise, `Rise[2]` = 1 and `Pulse[2]` = 0.
REQ-038 Channels 0 and 3 rise on the same edge, Mode=11 -> `Rise` = 4'b1001 and `Pulse` = 4'b1001 for one cycle, with `Any` = 1 for one cycle.
REQ-039 `Reset` = 0 pulsed at counter = 2 -> outputs 0 at once, no pulse; after release with input still high -> `Rise` after 6 cycles.
REQ-040 DEBOUNCE=1, SYNC_STAGES=3 -> latency 4 cycles; toggling input every 2 cycles -> alternating `Rise`/`Fall`, never coincident.
